// File: rtl/alu_op_stage.sv
// Two-entry skid-buffered issue stage feeding the ALU 3-to-8 operation decoder.
// Define ALU_OP_ILLEGAL_TRAP_EN to trap opcodes with in_opcode[4:3] != 0 instead of issuing them.
module alu_op_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        op_sel,
  output logic [4:0]        out_shamt,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              illegal_seen,
  output logic [7:0]        illegal_count
);

  logic [1:0]        count_q, count_d;
  logic [2:0]        head_sel_q, head_sel_d, skid_sel_q, skid_sel_d;
  logic [4:0]        head_shamt_q, head_shamt_d, skid_shamt_q, skid_shamt_d;
  logic [DATA_W-1:0] head_a_q, head_a_d, skid_a_q, skid_a_d;
  logic [DATA_W-1:0] head_b_q, head_b_d, skid_b_q, skid_b_d;
  logic              accept_s, pop_s, enq_s;

  // in_ready is decoded from registered occupancy only, so no path from out_ready
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  assign op_sel    = head_sel_q;
  assign out_shamt = head_shamt_q;
  assign out_a     = head_a_q;
  assign out_b     = head_b_q;

`ifdef ALU_OP_ILLEGAL_TRAP_EN
  logic       illegal_s, trap_s;
  logic       illegal_seen_q, illegal_seen_d;
  logic [7:0] illegal_count_q, illegal_count_d;

  assign illegal_s     = (in_opcode[4:3] != 2'b00);
  assign trap_s        = accept_s & illegal_s;
  assign enq_s         = accept_s & ~illegal_s;
  assign illegal_seen  = illegal_seen_q;
  assign illegal_count = illegal_count_q;

  // Trap bookkeeping; flush deliberately leaves it untouched
  always_comb begin
    illegal_seen_d  = illegal_seen_q | trap_s;
    illegal_count_d = illegal_count_q;
    if (trap_s && (illegal_count_q != 8'hFF)) begin
      illegal_count_d = illegal_count_q + 8'd1;
    end else begin
      illegal_count_d = illegal_count_q;
    end
  end

  // Trap state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_seen_q  <= 1'b0;
      illegal_count_q <= 8'd0;
    end else begin
      illegal_seen_q  <= illegal_seen_d;
      illegal_count_q <= illegal_count_d;
    end
  end
`else
  logic unused_opcode_hi_s;

  assign unused_opcode_hi_s = ^in_opcode[4:3];
  assign enq_s              = accept_s;
  assign illegal_seen       = 1'b0;
  assign illegal_count      = 8'd0;
`endif

  // Occupancy and head/skid data next-state
  always_comb begin
    count_d      = count_q;
    head_sel_d   = head_sel_q;
    head_shamt_d = head_shamt_q;
    head_a_d     = head_a_q;
    head_b_d     = head_b_q;
    skid_sel_d   = skid_sel_q;
    skid_shamt_d = skid_shamt_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (enq_s) begin
            head_sel_d   = in_opcode[2:0];
            head_shamt_d = in_shamt;
            head_a_d     = in_a;
            head_b_d     = in_b;
            count_d      = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end
        2'd1: begin
          case ({enq_s, pop_s})
            2'b10: begin
              skid_sel_d   = in_opcode[2:0];
              skid_shamt_d = in_shamt;
              skid_a_d     = in_a;
              skid_b_d     = in_b;
              count_d      = 2'd2;
            end
            2'b01: count_d = 2'd0;
            2'b11: begin
              head_sel_d   = in_opcode[2:0];
              head_shamt_d = in_shamt;
              head_a_d     = in_a;
              head_b_d     = in_b;
              count_d      = 2'd1;
            end
            default: count_d = 2'd1;
          endcase
        end
        2'd2: begin
          if (pop_s) begin
            head_sel_d   = skid_sel_q;
            head_shamt_d = skid_shamt_q;
            head_a_d     = skid_a_q;
            head_b_d     = skid_b_q;
            count_d      = 2'd1;
          end else begin
            count_d = 2'd2;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  // Occupancy, head and skid registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= 2'd0;
      head_sel_q   <= 3'd0;
      head_shamt_q <= 5'd0;
      head_a_q     <= {DATA_W{1'b0}};
      head_b_q     <= {DATA_W{1'b0}};
      skid_sel_q   <= 3'd0;
      skid_shamt_q <= 5'd0;
      skid_a_q     <= {DATA_W{1'b0}};
      skid_b_q     <= {DATA_W{1'b0}};
    end else begin
      count_q      <= count_d;
      head_sel_q   <= head_sel_d;
      head_shamt_q <= head_shamt_d;
      head_a_q     <= head_a_d;
      head_b_q     <= head_b_d;
      skid_sel_q   <= skid_sel_d;
      skid_shamt_q <= skid_shamt_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
    end
  end

endmodule

// File: tb/tb_alu_op_stage.sv
// Self-checking bench for alu_op_stage: directed steps with random data against a queue model.
// Follows ALU_OP_ILLEGAL_TRAP_EN the same way as the design.
module tb_alu_op_stage;
  localparam int DATA_W = 32;
`ifdef ALU_OP_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  sel;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic              clock = 1'b0;
  logic              reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]        in_opcode, in_shamt, out_shamt;
  logic [DATA_W-1:0] in_a, in_b, out_a, out_b;
  logic [2:0]        op_sel;
  logic              illegal_seen;
  logic [7:0]        illegal_count;

  op_t q[$];
  int  m_cnt = 0;
  bit  m_seen = 1'b0;
  int  n_assert = 0;
  int  n_fail = 0;

  always #5 clock = ~clock;

  alu_op_stage #(.DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_shamt(in_shamt), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .op_sel(op_sel),
    .out_shamt(out_shamt), .out_a(out_a), .out_b(out_b),
    .illegal_seen(illegal_seen), .illegal_count(illegal_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      chk("op_sel", {29'd0, op_sel}, {29'd0, q[0].sel});
      chk("out_shamt", {27'd0, out_shamt}, {27'd0, q[0].shamt});
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
    end
    chk("illegal_seen", {31'd0, illegal_seen}, {31'd0, m_seen});
    chk("illegal_count", {24'd0, illegal_count}, 32'(m_cnt));
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, update model after the edge.
  task automatic cycle(input bit v, input logic [4:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input bit ordy, input bit fl);
    op_t e;
    bit  acc, pp, ill;
    in_valid  = v;
    in_opcode = opc;
    in_shamt  = 5'($urandom);
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    e = '{sel: opc[2:0], shamt: in_shamt, a: a, b: b};
    @(negedge clock);
    check_model();
    acc = v && (q.size() < 2);
    pp  = (q.size() != 0) && ordy;
    ill = TRAP && (opc[4:3] != 2'b00);
    @(posedge clock);
    #1;
    if (acc && ill) begin
      m_seen = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc && !ill) q.push_back(e);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_op_sel"}, {29'd0, op_sel}, 32'd0);
    chk({tag, "_shamt"}, {27'd0, out_shamt}, 32'd0);
    chk({tag, "_a"}, out_a, 32'd0);
    chk({tag, "_b"}, out_b, 32'd0);
    chk({tag, "_seen"}, {31'd0, illegal_seen}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, illegal_count}, 32'd0);
  endtask

  function automatic logic [4:0] legal_op();
    return {2'b00, 3'($urandom)};
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 5'd0; in_shamt = 5'd0; in_a = 32'd0; in_b = 32'd0;
    #3;
    chk_reset_vals("por");
    @(posedge clock);
    #2 reset_n = 1'b1;

    // single op, popped immediately
    cycle(1'b1, 5'd3, 32'h10, 32'h20, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_sel", {29'd0, op_sel}, 32'd3);
    chk("t1_a", out_a, 32'h10);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // back-pressure: 1,2,4 with ALU stalled, third refused
    cycle(1'b1, 5'd1, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 5'd2, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 5'd4, $urandom, $urandom, 1'b0, 1'b0);
    chk("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 5'd4, $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b1, 5'd4, $urandom, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // full-rate stream
    for (int i = 0; i < 16; i++) cycle(1'b1, legal_op(), $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // flush with two entries queued, plus a same-cycle accept attempt
    cycle(1'b1, legal_op(), $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, legal_op(), $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, legal_op(), $urandom, $urandom, 1'b1, 1'b1);
    chk("t4_flushed_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_flushed_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // flush while an illegal op is accepted
    cycle(1'b1, 5'b11001, $urandom, $urandom, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // repeated illegal opcode saturates the counter
    for (int i = 0; i < 300; i++) cycle(1'b1, 5'b01000, $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t5_seen", {31'd0, illegal_seen}, TRAP ? 32'd1 : 32'd0);
    chk("t5_cnt_sat", {24'd0, illegal_count}, TRAP ? 32'd255 : 32'd0);

    // random mix of handshakes, flushes and opcodes
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 5'($urandom), $urandom, $urandom,
            1'($urandom), ($urandom_range(0, 15) == 0));

    // asynchronous reset with the queue full
    while (q.size() < 2) cycle(1'b1, legal_op(), $urandom, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    q.delete();
    m_cnt = 0;
    m_seen = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    cycle(1'b1, 5'd6, $urandom, $urandom, 1'b0, 1'b0);
    chk("t6_first_accept", {31'd0, out_valid}, 32'd1);
    chk("t6_sel", {29'd0, op_sel}, 32'd6);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
